// File: rtl/vec_mem_arbiter_if.sv
// Request/response and memory-side signals between the two requesters, the arbiter and the
// single-port vector memory.
interface vec_mem_arbiter_if #(
  parameter int unsigned dataSize       = 32,
  parameter int unsigned addressingSize = 32,
  parameter int unsigned vecSize        = 4
);
  localparam int unsigned VecW = dataSize * vecSize;

  logic                      req0_valid;
  logic                      req0_write;
  logic [addressingSize-1:0] req0_addr;
  logic [VecW-1:0]           req0_wdata;
  logic                      req0_ready;
  logic                      req0_rvalid;
  logic [VecW-1:0]           req0_rdata;

  logic                      req1_valid;
  logic                      req1_write;
  logic [addressingSize-1:0] req1_addr;
  logic [VecW-1:0]           req1_wdata;
  logic                      req1_ready;
  logic                      req1_rvalid;
  logic [VecW-1:0]           req1_rdata;

  logic                      mem_writeEnable;
  logic [addressingSize-1:0] mem_DataAdr;
  logic [VecW-1:0]           mem_toWrite_data;
  logic [VecW-1:0]           mem_read_data;

  // Requester/memory-model side.
  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    input  req0_ready, req0_rvalid, req0_rdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_ready, req1_rvalid, req1_rdata,
    input  mem_writeEnable, mem_DataAdr, mem_toWrite_data,
    output mem_read_data
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    output req0_ready, req0_rvalid, req0_rdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_ready, req1_rvalid, req1_rdata,
    output mem_writeEnable, mem_DataAdr, mem_toWrite_data,
    input  mem_read_data
  );
endinterface

// File: rtl/vec_mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-port vector data memory.
// Writes take two cycles (IDLE, ISSUE), reads three (IDLE, ISSUE, CAPTURE).
module vec_mem_arbiter #(
  parameter int unsigned dataSize       = 32,
  parameter int unsigned addressingSize = 32,
  parameter int unsigned vecSize        = 4,
  parameter int unsigned cntWidth       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  vec_mem_arbiter_if.slave    bus,
  output logic                busy,
  output logic [cntWidth-1:0] grant_count0,
  output logic [cntWidth-1:0] grant_count1
);
  localparam int unsigned VecW = dataSize * vecSize;

  typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

  state_e                    state_q, state_d;
  logic                      last_grant_q, last_grant_d;
  logic                      write_q, write_d;
  logic                      port_q, port_d;
  logic [addressingSize-1:0] addr_q, addr_d;
  logic [VecW-1:0]           wdata_q, wdata_d;
  logic [cntWidth-1:0]       cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [VecW-1:0]           rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                      rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic                      gnt0, gnt1, ready0, ready1;

  always_comb begin
    // last_grant_q == 1 means port 1 was served last, so port 0 wins a tie.
    gnt0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
    gnt1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);

    state_d      = state_q;
    last_grant_d = last_grant_q;
    write_d      = write_q;
    port_d       = port_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    ready0       = 1'b0;
    ready1       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (gnt0) begin
          ready0       = 1'b1;
          write_d      = bus.req0_write;
          addr_d       = bus.req0_addr;
          wdata_d      = bus.req0_wdata;
          port_d       = 1'b0;
          last_grant_d = 1'b0;
          if (cnt0_q != {cntWidth{1'b1}}) cnt0_d = cnt0_q + 1'b1;
          state_d      = StIssue;
        end else if (gnt1) begin
          ready1       = 1'b1;
          write_d      = bus.req1_write;
          addr_d       = bus.req1_addr;
          wdata_d      = bus.req1_wdata;
          port_d       = 1'b1;
          last_grant_d = 1'b1;
          if (cnt1_q != {cntWidth{1'b1}}) cnt1_d = cnt1_q + 1'b1;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        state_d = write_q ? StIdle : StCapture;
      end
      StCapture: begin
        if (port_q) begin
          rdata1_d  = bus.mem_read_data;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = bus.mem_read_data;
          rvalid0_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      write_q      <= 1'b0;
      port_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      port_q       <= port_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
    end
  end

  // Address and data stay on the registered request so idle cycles are harmless reads.
  assign bus.mem_writeEnable  = (state_q == StIssue) && write_q;
  assign bus.mem_DataAdr      = addr_q;
  assign bus.mem_toWrite_data = wdata_q;

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.req0_rvalid = rvalid0_q;
  assign bus.req1_rvalid = rvalid1_q;
  assign bus.req0_rdata  = rdata0_q;
  assign bus.req1_rdata  = rdata1_q;

  assign busy         = (state_q != StIdle);
  assign grant_count0 = cnt0_q;
  assign grant_count1 = cnt1_q;
endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Bench for vec_mem_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level timing model and a reference memory image.
module tb_vec_mem_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned VS = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned VW = DW * VS;
  localparam int          CntMax = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          busy;
  logic [CW-1:0] gc0, gc1;

  always #5 clk = ~clk;

  vec_mem_arbiter_if #(.dataSize(DW), .addressingSize(AW), .vecSize(VS)) bus ();

  vec_mem_arbiter #(
    .dataSize(DW), .addressingSize(AW), .vecSize(VS), .cntWidth(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy),
    .grant_count0(gc0), .grant_count1(gc1)
  );

  // Registered single-port memory, indexed by address bits [11:4].
  logic [VW-1:0] tb_mem [256];
  always @(posedge clk) begin
    if (bus.mem_writeEnable) tb_mem[bus.mem_DataAdr[11:4]] <= bus.mem_toWrite_data;
    bus.mem_read_data <= tb_mem[bus.mem_DataAdr[11:4]];
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: cycles still busy, pending response countdown, expected outputs.
  int            busy_left;
  bit            m_last;
  int            resp_cnt;
  int            resp_port;
  logic [VW-1:0] resp_data;
  bit            exp_rv [2];
  logic [VW-1:0] exp_rd [2];
  int            exp_cnt [2];
  bit            exp_we;
  logic [AW-1:0] exp_adr;
  logic [VW-1:0] exp_wd;
  logic [VW-1:0] ref_mem [256];

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    busy_left = 0; m_last = 1'b1; resp_cnt = 0; resp_port = 0; resp_data = '0;
    exp_we = 1'b0; exp_adr = '0; exp_wd = '0;
    for (int i = 0; i < 2; i++) begin
      exp_rv[i] = 1'b0; exp_rd[i] = '0; exp_cnt[i] = 0;
    end
  endtask

  function automatic logic [VW-1:0] rvec();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive(input int p, input bit v, input bit w, input logic [AW-1:0] a,
                       input logic [VW-1:0] d);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_write = w; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_write = w; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  // Called at a falling edge with inputs already driven; returns the port the DUT accepted.
  task automatic step(output int acc);
    bit v0, v1, w0, w1, er0, er1;
    logic [AW-1:0] a0, a1, a;
    logic [VW-1:0] d0, d1, d;
    bit w;
    int p;
    #1;
    v0 = bus.req0_valid; w0 = bus.req0_write; a0 = bus.req0_addr; d0 = bus.req0_wdata;
    v1 = bus.req1_valid; w1 = bus.req1_write; a1 = bus.req1_addr; d1 = bus.req1_wdata;
    er0 = (busy_left == 0) && v0 && (!v1 || m_last);
    er1 = (busy_left == 0) && v1 && (!v0 || !m_last);
    acc = bus.req1_ready ? 1 : (bus.req0_ready ? 0 : -1);
    check("ready0", bus.req0_ready, er0);
    check("ready1", bus.req1_ready, er1);
    check("busy", busy, busy_left != 0);
    check("rvalid0", bus.req0_rvalid, exp_rv[0]);
    check("rvalid1", bus.req1_rvalid, exp_rv[1]);
    check("rdata0", bus.req0_rdata, exp_rd[0]);
    check("rdata1", bus.req1_rdata, exp_rd[1]);
    check("grant_count0", gc0, exp_cnt[0]);
    check("grant_count1", gc1, exp_cnt[1]);
    check("mem_we", bus.mem_writeEnable, exp_we);
    check("mem_adr", bus.mem_DataAdr, exp_adr);
    if (exp_we) check("mem_wdata", bus.mem_toWrite_data, exp_wd);
    @(posedge clk);
    cyc++;
    exp_we = 1'b0;
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    if (busy_left > 0) busy_left--;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        exp_rv[resp_port] = 1'b1;
        exp_rd[resp_port] = resp_data;
      end
    end
    if (er0 || er1) begin
      p = er1 ? 1 : 0;
      w = er1 ? w1 : w0;
      a = er1 ? a1 : a0;
      d = er1 ? d1 : d0;
      m_last = (p == 1);
      if (exp_cnt[p] < CntMax) exp_cnt[p]++;
      exp_adr = a;
      exp_wd = d;
      if (w) begin
        busy_left = 1; exp_we = 1'b1; ref_mem[a[11:4]] = d;
      end else begin
        busy_left = 2; resp_cnt = 2; resp_port = p; resp_data = ref_mem[a[11:4]];
      end
    end
    @(negedge clk);
  endtask

  // Hold a request until the DUT accepts it (bounded), then withdraw it.
  task automatic request(input int p, input bit w, input logic [AW-1:0] a,
                         input logic [VW-1:0] d);
    int acc;
    bit got = 1'b0;
    drive(p, 1'b1, w, a, d);
    for (int i = 0; i < 10 && !got; i++) begin
      step(acc);
      if (acc == p) got = 1'b1;
    end
    check("accepted", got, 1'b1);
    drive(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic idle(input int n);
    int acc;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  initial begin
    int acc;
    int grants [$];
    int gcyc [$];
    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = '0; ref_mem[i] = '0;
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_we", bus.mem_writeEnable, 1'b0);
    check("rst_adr", bus.mem_DataAdr, '0);
    check("rst_wdata", bus.mem_toWrite_data, '0);
    check("rst_rdata0", bus.req0_rdata, '0);
    check("rst_rvalid1", bus.req1_rvalid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Port 0 write then read back.
    request(0, 1'b1, 32'h10, {32'd4, 32'd3, 32'd2, 32'd1});
    idle(1);
    request(0, 1'b0, 32'h10, '0);
    idle(2);
    #1;
    check("t1_rvalid0", bus.req0_rvalid, 1'b1);
    check("t1_rdata0", bus.req0_rdata, {32'd4, 32'd3, 32'd2, 32'd1});
    check("t1_rvalid1", bus.req1_rvalid, 1'b0);
    idle(1);

    // Reset asserted during CAPTURE of a port-0 read.
    request(0, 1'b0, 32'h10, '0);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    check("rc_rvalid0", bus.req0_rvalid, 1'b0);
    check("rc_rdata0", bus.req0_rdata, '0);
    check("rc_busy", busy, 1'b0);
    check("rc_gc0", gc0, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Both ports request reads continuously from reset: strict alternation, 3 cycles apart.
    drive(0, 1'b1, 1'b0, 32'h10, '0);
    drive(1, 1'b1, 1'b0, 32'h20, '0);
    for (int i = 0; i < 11; i++) begin
      step(acc);
      if (acc >= 0) begin
        grants.push_back(acc);
        gcyc.push_back(cyc);
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    check("tie_ngrants", grants.size(), 4);
    for (int i = 0; i < grants.size(); i++) begin
      check("tie_order", grants[i], i % 2);
      if (i > 0) check("tie_spacing", gcyc[i] - gcyc[i-1], 3);
    end
    idle(3);
    check("tie_gc0", gc0, 2);
    check("tie_gc1", gc1, 2);

    // Port 1 alone: back-to-back writes every 2 cycles.
    gcyc.delete();
    drive(1, 1'b1, 1'b1, {$urandom_range(0, 255), 4'h0}, rvec());
    for (int i = 0; i < 8; i++) begin
      step(acc);
      if (acc == 1) begin
        gcyc.push_back(cyc);
        drive(1, 1'b1, 1'b1, {$urandom_range(0, 255), 4'h0}, rvec());
      end
    end
    drive(1, 1'b0, 1'b0, '0, '0);
    check("p1_nwrites", gcyc.size(), 4);
    for (int i = 1; i < gcyc.size(); i++) check("p1_spacing", gcyc[i] - gcyc[i-1], 2);
    idle(2);
    drive(1, 1'b1, 1'b0, 32'h20, '0);
    step(acc);
    check("p1_lone_wins", acc, 1);
    drive(1, 1'b0, 1'b0, '0, '0);
    idle(3);

    // Port 1 raises valid and withdraws it while port 0 is being served.
    request(0, 1'b0, 32'h30, '0);
    drive(1, 1'b1, 1'b0, 32'h40, '0);
    step(acc);
    check("wd_no_grant", acc, -1);
    drive(1, 1'b0, 1'b0, '0, '0);
    idle(4);

    // Counter saturation after five port-0 accepts.
    @(negedge clk);
    rst_n = 1'b0;
    #1 model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) request(0, 1'b1, {$urandom_range(0, 255), 4'h0}, rvec());
    idle(1);
    check("sat_gc0", gc0, 3);

    // Random traffic with requests that may change or withdraw at any cycle.
    for (int i = 0; i < 300; i++) begin
      for (int p = 0; p < 2; p++)
        drive(p, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
              $urandom_range(0, 255) << 4, rvec());
      step(acc);
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
